// File: rtl/fifo_pkg.sv
// fifo_pkg: sizing helpers shared by the fifo_pkt slice.
//   clogb2(v)        bits needed to represent v (clogb2(4) = 3, clogb2(0) = 0)
//   actual_depth(d)  ACTUAL_DEPTH = 2**clogb2(d-1)
//   ptr_width(d)     PW = clogb2(d-1) + 1; the pointer MSB is the wrap bit
package fifo_pkg;

  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int unsigned actual_depth(input int unsigned depth);
    return 32'd1 << clogb2(depth - 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return clogb2(depth - 1) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage for fifo_pkt.
//   CLK    write clock
//   WE     write enable; WDATA is stored at WADDR on the rising edge
//   WADDR  write address
//   WDATA  write word
//   RADDR  read address
//   RDATA  asynchronous read of mem[RADDR]
// Contents are not reset.
module fifo_ram #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned AW    = 5
) (
  input  logic             CLK,
  input  logic             WE,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] WDATA,
  input  logic [AW-1:0]    RADDR,
  output logic [WIDTH-1:0] RDATA
);

  logic [WIDTH-1:0] mem [1 << AW];

  always_ff @(posedge CLK) begin
    if (WE) mem[WADDR] <= WDATA;
  end

  assign RDATA = mem[RADDR];

endmodule

// File: rtl/fifo_pkt.sv
// fifo_pkt: single-clock first-word-fall-through FIFO with occupancy count,
// almost-full/almost-empty flags, sticky error flags and optional packet mode.
//   CLK, RESETN      clock, asynchronous active-low reset
//   DIN, DIN_LAST    write word and its frame-end marker (stored together)
//   WE               write request (accepted when !FULL)
//   WR_DROP          packet mode: discard the uncommitted frame
//   FULL             no free entry (counts uncommitted words)
//   ALMOST_FULL      write-side occupancy >= AFULL_THRESH
//   DOUT, DOUT_LAST  head word, valid while NOT_EMPTY
//   RE               pop the head word (accepted when NOT_EMPTY)
//   NOT_EMPTY        at least one committed word present
//   ALMOST_EMPTY     DATA_COUNT <= AEMPTY_THRESH
//   DATA_COUNT       committed, unread words
//   OVERFLOW         sticky: write attempted while FULL
//   UNDERFLOW        sticky: read attempted while empty
//   CLR_ERR          synchronous clear of both sticky flags (set wins)
// DEPTH must be at least 2.
module fifo_pkt
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 32,
  parameter int unsigned AFULL_THRESH  = actual_depth(DEPTH) - 2,
  parameter int unsigned AEMPTY_THRESH = 2,
  parameter bit          PACKET_MODE   = 1'b0
) (
  input  logic                         CLK,
  input  logic                         RESETN,
  input  logic [WIDTH-1:0]             DIN,
  input  logic                         DIN_LAST,
  input  logic                         WE,
  input  logic                         WR_DROP,
  output logic                         FULL,
  output logic                         ALMOST_FULL,
  output logic [WIDTH-1:0]             DOUT,
  output logic                         DOUT_LAST,
  input  logic                         RE,
  output logic                         NOT_EMPTY,
  output logic                         ALMOST_EMPTY,
  output logic [ptr_width(DEPTH)-1:0]  DATA_COUNT,
  output logic                         OVERFLOW,
  output logic                         UNDERFLOW,
  input  logic                         CLR_ERR
);

  localparam int unsigned ACTUAL_DEPTH = actual_depth(DEPTH);
  localparam int unsigned PW           = ptr_width(DEPTH);
  localparam int unsigned AW           = PW - 1;
  localparam logic [PW-1:0] DEPTH_P    = PW'(ACTUAL_DEPTH);

  logic [PW-1:0]  wp, wc, rp;
  logic [PW-1:0]  wp_d, wc_d, rp_d;
  logic [PW-1:0]  wocc_d, rocc_d;
  logic           wr_ok, rd_ok, drop, ram_we, bypass;
  logic [WIDTH:0] ram_rd, head_d;

  always_comb begin
    wr_ok  = WE & ~FULL;
    rd_ok  = RE & NOT_EMPTY;
    drop   = WR_DROP & PACKET_MODE;
    wp_d   = drop ? wc : wp + PW'(wr_ok);
    if (PACKET_MODE) wc_d = (wr_ok & DIN_LAST & ~drop) ? wp_d : wc;
    else             wc_d = wp_d;
    rp_d   = rp + PW'(rd_ok);
    wocc_d = wp_d - rp_d;
    rocc_d = wc_d - rp_d;
    ram_we = wr_ok & ~drop;
    // A write landing on the next head address can only happen when the
    // FIFO is otherwise empty, so the incoming word is the new head.
    bypass = ram_we & (wp[AW-1:0] == rp_d[AW-1:0]);
    head_d = bypass ? {DIN_LAST, DIN} : ram_rd;
  end

  fifo_ram #(
    .WIDTH (WIDTH + 1),
    .AW    (AW)
  ) u_ram (
    .CLK   (CLK),
    .WE    (ram_we),
    .WADDR (wp[AW-1:0]),
    .WDATA ({DIN_LAST, DIN}),
    .RADDR (rp_d[AW-1:0]),
    .RDATA (ram_rd)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wp           <= '0;
      wc           <= '0;
      rp           <= '0;
      FULL         <= 1'b0;
      ALMOST_FULL  <= 1'b0;
      NOT_EMPTY    <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
      DATA_COUNT   <= '0;
      DOUT         <= '0;
      DOUT_LAST    <= 1'b0;
      OVERFLOW     <= 1'b0;
      UNDERFLOW    <= 1'b0;
    end else begin
      wp           <= wp_d;
      wc           <= wc_d;
      rp           <= rp_d;
      FULL         <= (wocc_d == DEPTH_P);
      ALMOST_FULL  <= (32'(wocc_d) >= AFULL_THRESH);
      NOT_EMPTY    <= (wc_d != rp_d);
      ALMOST_EMPTY <= (32'(rocc_d) <= AEMPTY_THRESH);
      DATA_COUNT   <= rocc_d;
      // Head register only follows the RAM while a committed word exists;
      // otherwise it keeps the last word presented.
      if (wc_d != rp_d) {DOUT_LAST, DOUT} <= head_d;
      OVERFLOW     <= (WE & FULL) | (OVERFLOW & ~CLR_ERR);
      UNDERFLOW    <= (RE & ~NOT_EMPTY) | (UNDERFLOW & ~CLR_ERR);
    end
  end

endmodule

// File: tb/tb_fifo_pkt.sv
// Bench for fifo_pkt: d0 is stream mode (DEPTH=5 -> 8 entries, default
// thresholds 6/2), d1 is packet mode (DEPTH=8, thresholds 4/1). Both see
// the same inputs and are tracked every cycle by a queue-based model.
module tb_fifo_pkt;

  typedef logic [8:0] word_t;

  typedef struct {
    bit         we, re;
    logic [7:0] din;
    bit         full, af, ne, ae, ovf;
    logic [3:0] cnt;
    logic [7:0] dout;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic [7:0] DIN = '0;
  logic       DIN_LAST = 1'b0, WE = 1'b0, WR_DROP = 1'b0, RE = 1'b0, CLR_ERR = 1'b0;

  logic       FULL0, AF0, NE0, AE0, OVF0, UNF0, DL0;
  logic [7:0] DOUT0;
  logic [3:0] CNT0;
  logic       FULL1, AF1, NE1, AE1, OVF1, UNF1, DL1;
  logic [7:0] DOUT1;
  logic [3:0] CNT1;

  logic [18:0] act0, act1;
  assign act0 = {FULL0, AF0, NE0, AE0, OVF0, UNF0, DL0, DOUT0, CNT0};
  assign act1 = {FULL1, AF1, NE1, AE1, OVF1, UNF1, DL1, DOUT1, CNT1};

  localparam logic [18:0] RESET_VEC = 19'h08000;  // only ALMOST_EMPTY set

  fifo_pkt #(.WIDTH(8), .DEPTH(5), .PACKET_MODE(1'b0)) d0 (
    .CLK(CLK), .RESETN(RESETN), .DIN(DIN), .DIN_LAST(DIN_LAST), .WE(WE),
    .WR_DROP(WR_DROP), .FULL(FULL0), .ALMOST_FULL(AF0), .DOUT(DOUT0),
    .DOUT_LAST(DL0), .RE(RE), .NOT_EMPTY(NE0), .ALMOST_EMPTY(AE0),
    .DATA_COUNT(CNT0), .OVERFLOW(OVF0), .UNDERFLOW(UNF0), .CLR_ERR(CLR_ERR)
  );

  fifo_pkt #(.WIDTH(8), .DEPTH(8), .AFULL_THRESH(4), .AEMPTY_THRESH(1),
             .PACKET_MODE(1'b1)) d1 (
    .CLK(CLK), .RESETN(RESETN), .DIN(DIN), .DIN_LAST(DIN_LAST), .WE(WE),
    .WR_DROP(WR_DROP), .FULL(FULL1), .ALMOST_FULL(AF1), .DOUT(DOUT1),
    .DOUT_LAST(DL1), .RE(RE), .NOT_EMPTY(NE1), .ALMOST_EMPTY(AE1),
    .DATA_COUNT(CNT1), .OVERFLOW(OVF1), .UNDERFLOW(UNF1), .CLR_ERR(CLR_ERR)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  // Model: each queue holds stored words oldest first; the first nc[i] are
  // committed (readable), the rest belong to the open frame.
  word_t       q0[$], q1[$];
  int          nc[2];
  bit          m_ovf[2], m_unf[2];
  word_t       m_head[2];
  logic [18:0] m_exp[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic model_exp(input int i, input int aft, input int aet, ref word_t q[$]);
    if (nc[i] > 0) m_head[i] = q[0];
    m_exp[i] = {q.size() == 8, q.size() >= aft, nc[i] > 0, nc[i] <= aet,
                m_ovf[i], m_unf[i], m_head[i], 4'(nc[i])};
  endtask

  task automatic model_step(input int i, input bit pm, input int aft, input int aet,
                            ref word_t q[$]);
    bit full, ne;
    full = (q.size() == 8);
    ne   = (nc[i] > 0);
    m_ovf[i] = (WE && full) ? 1'b1 : (CLR_ERR ? 1'b0 : m_ovf[i]);
    m_unf[i] = (RE && !ne)  ? 1'b1 : (CLR_ERR ? 1'b0 : m_unf[i]);
    if (RE && ne) begin
      q.delete(0);
      nc[i]--;
    end
    if (pm && WR_DROP) begin
      while (q.size() > nc[i]) q.delete(q.size() - 1);
    end else if (WE && !full) begin
      q.push_back({DIN_LAST, DIN});
      if (!pm || DIN_LAST) nc[i] = q.size();
    end
    model_exp(i, aft, aet, q);
  endtask

  task automatic models_reset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      nc[i] = 0; m_ovf[i] = 1'b0; m_unf[i] = 1'b0; m_head[i] = '0;
    end
    model_exp(0, 6, 2, q0);
    model_exp(1, 4, 1, q1);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step(0, 1'b0, 6, 2, q0);
    model_step(1, 1'b1, 4, 1, q1);
    #1;
    chk("d0 vs model", act0, m_exp[0]);
    chk("d1 vs model", act1, m_exp[1]);
  endtask

  task automatic step(input bit we, input bit re, input logic [7:0] d,
                      input bit last, input bit drop, input bit clr);
    WE = we; RE = re; DIN = d; DIN_LAST = last; WR_DROP = drop; CLR_ERR = clr;
    tick();
  endtask

  task automatic do_reset();
    RESETN = 1'b0;
    WE = 1'b0; RE = 1'b0; WR_DROP = 1'b0; CLR_ERR = 1'b0; DIN_LAST = 1'b0; DIN = '0;
    @(posedge CLK);
    #2;
    models_reset();
    chk("reset d0", act0, RESET_VEC);
    chk("reset d1", act1, RESET_VEC);
    RESETN = 1'b1;
  endtask

  function automatic vec_t mk(bit we, bit re, logic [7:0] din, bit full, bit af, bit ne,
                              bit ae, bit ovf, logic [3:0] cnt, logic [7:0] dout);
    vec_t v;
    v.we = we; v.re = re; v.din = din; v.full = full; v.af = af; v.ne = ne;
    v.ae = ae; v.ovf = ovf; v.cnt = cnt; v.dout = dout;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    //          we re din    full af ne ae ovf cnt dout
    tbl[0]  = mk(1, 0, 8'h01, 0, 0, 1, 1, 0, 4'd1, 8'h01);
    tbl[1]  = mk(1, 0, 8'h02, 0, 0, 1, 1, 0, 4'd2, 8'h01);
    tbl[2]  = mk(1, 0, 8'h03, 0, 0, 1, 0, 0, 4'd3, 8'h01);
    tbl[3]  = mk(1, 0, 8'h04, 0, 0, 1, 0, 0, 4'd4, 8'h01);
    tbl[4]  = mk(1, 0, 8'h05, 0, 0, 1, 0, 0, 4'd5, 8'h01);
    tbl[5]  = mk(1, 0, 8'h06, 0, 1, 1, 0, 0, 4'd6, 8'h01);
    tbl[6]  = mk(1, 0, 8'h07, 0, 1, 1, 0, 0, 4'd7, 8'h01);
    tbl[7]  = mk(1, 0, 8'h08, 1, 1, 1, 0, 0, 4'd8, 8'h01);
    tbl[8]  = mk(1, 0, 8'h09, 1, 1, 1, 0, 1, 4'd8, 8'h01);
    tbl[9]  = mk(0, 1, 8'h00, 0, 1, 1, 0, 1, 4'd7, 8'h02);
    tbl[10] = mk(0, 1, 8'h00, 0, 1, 1, 0, 1, 4'd6, 8'h03);
    tbl[11] = mk(0, 1, 8'h00, 0, 0, 1, 0, 1, 4'd5, 8'h04);
    tbl[12] = mk(0, 1, 8'h00, 0, 0, 1, 0, 1, 4'd4, 8'h05);
    tbl[13] = mk(0, 1, 8'h00, 0, 0, 1, 0, 1, 4'd3, 8'h06);
    tbl[14] = mk(0, 1, 8'h00, 0, 0, 1, 1, 1, 4'd2, 8'h07);
    tbl[15] = mk(0, 1, 8'h00, 0, 0, 1, 1, 1, 4'd1, 8'h08);
    tbl[16] = mk(0, 1, 8'h00, 0, 0, 0, 1, 1, 4'd0, 8'h08);

    // Stream mode fill to FULL, rejected 9th write, drain.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      step(tbl[k].we, tbl[k].re, tbl[k].din, 1'b0, 1'b0, 1'b0);
      chk($sformatf("fill row %0d", k), {FULL0, AF0, NE0, AE0, OVF0, CNT0, DOUT0},
          {tbl[k].full, tbl[k].af, tbl[k].ne, tbl[k].ae, tbl[k].ovf, tbl[k].cnt, tbl[k].dout});
    end

    // Fall-through from empty.
    do_reset();
    step(1, 0, 8'hA5, 0, 0, 0);
    chk("bypass ne/cnt/dout", {NE0, CNT0, DOUT0}, {1'b1, 4'd1, 8'hA5});
    step(0, 1, 8'h00, 0, 0, 0);
    chk("bypass pop ne/ae", {NE0, AE0}, 2'b01);

    // Sustained read+write at count 3 across pointer wraps.
    do_reset();
    for (int k = 1; k <= 3; k++) step(1, 0, 8'(k), 0, 0, 0);
    for (int j = 0; j < 20; j++) begin
      step(1, 1, 8'(4 + j), 0, 0, 0);
      chk($sformatf("wrap %0d", j), {FULL0, NE0, CNT0, DOUT0}, {1'b0, 1'b1, 4'd3, 8'(j + 2)});
    end

    // Packet mode: no visibility until LAST.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 8'(8'h11 + k), 0, 0, 0);
      chk($sformatf("nolast %0d ne", k), NE1, 1'b0);
    end
    step(1, 0, 8'h14, 1, 0, 0);
    chk("commit ne/cnt/dout", {NE1, CNT1, DOUT1}, {1'b1, 4'd4, 8'h11});
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("frame read %0d", k), {DL1, DOUT1}, {k == 3, 8'(8'h11 + k)});
      step(0, 1, 8'h00, 0, 0, 0);
    end
    chk("frame drained ne", NE1, 1'b0);

    // Packet mode: drop of a partial frame behind a committed one.
    do_reset();
    step(1, 0, 8'h21, 0, 0, 0);
    step(1, 0, 8'h22, 1, 0, 0);
    step(1, 0, 8'h31, 0, 0, 0);
    step(1, 0, 8'h32, 0, 0, 0);
    chk("pre-drop af", AF1, 1'b1);
    step(0, 0, 8'h00, 0, 1, 0);
    chk("drop cnt/full/af", {CNT1, FULL1, AF1}, {4'd2, 1'b0, 1'b0});
    chk("drop head A0", {DL1, DOUT1}, {1'b0, 8'h21});
    step(0, 1, 8'h00, 0, 0, 0);
    chk("drop head A1", {DL1, DOUT1}, {1'b1, 8'h22});
    step(0, 1, 8'h00, 0, 0, 0);
    chk("drop drained", NE1, 1'b0);
    step(1, 0, 8'h41, 0, 0, 0);
    step(1, 0, 8'h42, 1, 1, 0);
    chk("drop on last", {NE1, CNT1, FULL1}, {1'b0, 4'd0, 1'b0});
    step(1, 0, 8'h51, 1, 0, 0);
    chk("after drop head", {NE1, CNT1, DL1, DOUT1}, {1'b1, 4'd1, 1'b1, 8'h51});

    // Packet mode: oversized frame deadlock released by WR_DROP.
    do_reset();
    for (int k = 0; k < 8; k++) step(1, 0, 8'(k), 0, 0, 0);
    chk("big frame full/ne", {FULL1, NE1}, 2'b10);
    step(1, 0, 8'hFF, 1, 0, 0);
    chk("big frame ovf/ne", {OVF1, NE1}, 2'b10);
    step(0, 0, 8'h00, 0, 1, 0);
    chk("big frame released", {FULL1, NE1, AF1}, 3'b000);

    // Sticky underflow and its clear priority.
    do_reset();
    step(0, 1, 8'h00, 0, 0, 0);
    chk("underflow set", UNF0, 1'b1);
    step(0, 0, 8'h00, 0, 0, 1);
    chk("underflow clr", UNF0, 1'b0);
    step(0, 1, 8'h00, 0, 0, 1);
    chk("underflow set beats clr", UNF0, 1'b1);

    // Asynchronous reset mid-frame, no clock edge in between.
    do_reset();
    step(1, 0, 8'h61, 0, 0, 0);
    step(1, 0, 8'h62, 0, 0, 0);
    WE = 1'b0;
    #1;
    RESETN = 1'b0;
    #1;
    chk("async reset d0", act0, RESET_VEC);
    chk("async reset d1", act1, RESET_VEC);
    models_reset();
    @(posedge CLK);
    #2;
    RESETN = 1'b1;

    // Random traffic, alternating fill-heavy and drain-heavy phases.
    for (int n = 0; n < 600; n++) begin
      bit fill_phase;
      fill_phase = ((n / 75) % 2) == 0;
      WE       = $urandom_range(99) < (fill_phase ? 75 : 35);
      RE       = $urandom_range(99) < (fill_phase ? 35 : 75);
      DIN      = 8'($urandom);
      DIN_LAST = ($urandom_range(3) == 0);
      WR_DROP  = ($urandom_range(19) == 0);
      CLR_ERR  = ($urandom_range(29) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
